// File: rtl/rf_writeback_ctrl.sv
// Register-file write-back controller: in-order write queue fed by ALU and memory producers,
// drained one entry per cycle, with pending bitmap and two forwarding ports. Optional macro: WB_R0_ZERO_EN.
module rf_writeback_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = 4,
    parameter int DW    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [AW-1:0]         alu_addr,
    input  logic [DW-1:0]         alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [AW-1:0]         mem_addr,
    input  logic [DW-1:0]         mem_data,
    output logic                  rf_wen,
    output logic [AW-1:0]         rf_waddr,
    output logic [DW-1:0]         rf_wdata,
    output logic [(1<<AW)-1:0]    pending,
    input  logic [AW-1:0]         fwd_addr1,
    input  logic [AW-1:0]         fwd_addr2,
    output logic                  fwd_hit1,
    output logic                  fwd_hit2,
    output logic [DW-1:0]         fwd_data1,
    output logic [DW-1:0]         fwd_data2,
    output logic                  full,
    output logic                  empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int NR = 1 << AW;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-1:0] addr_q [DEPTH];
    logic [AW-1:0] addr_d [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [DW-1:0] data_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          rf_wen_q, rf_wen_d;
    logic [AW-1:0] rf_waddr_q, rf_waddr_d;
    logic [DW-1:0] rf_wdata_q, rf_wdata_d;

    logic [CW-1:0] free_s;
    logic          mem_ready_s, alu_ready_s;
    logic          mem_acc_s, alu_acc_s;
    logic          mem_enq_s, alu_enq_s;
    logic          pop_s;
    logic [PW-1:0] alu_slot_s;

    logic [NR-1:0] pending_s;
    logic          hit1_s, hit2_s;
    logic [DW-1:0] data1_s, data2_s;
    logic [PW-1:0] scan_idx_s;
    logic          slot_valid_s;
    logic          match1_s, match2_s;

    // Handshake: readiness from free slots only; same-cycle pops are not credited.
    always_comb begin
        free_s      = DEPTH_C - count_q;
        mem_ready_s = (free_s >= CW'(1));
        alu_ready_s = (free_s >= CW'(2)) | ((free_s == CW'(1)) & ~mem_valid);
        mem_acc_s   = mem_valid & mem_ready_s;
        alu_acc_s   = alu_valid & alu_ready_s;
`ifdef WB_R0_ZERO_EN
        // Writes to the hardwired-zero register are consumed but never queued.
        mem_enq_s   = mem_acc_s & (mem_addr != {AW{1'b0}});
        alu_enq_s   = alu_acc_s & (alu_addr != {AW{1'b0}});
`else
        mem_enq_s   = mem_acc_s;
        alu_enq_s   = alu_acc_s;
`endif
        pop_s       = (count_q != {CW{1'b0}});
    end

    // Queue next state: pop head into the write port, then enqueue mem (older) before ALU.
    always_comb begin
        addr_d     = addr_q;
        data_d     = data_q;
        head_d     = head_q;
        rf_wen_d   = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (pop_s) begin
            rf_wen_d   = 1'b1;
            rf_waddr_d = addr_q[head_q];
            rf_wdata_d = data_q[head_q];
            head_d     = head_q + PW'(1);
        end else begin
            rf_wen_d   = 1'b0;
        end
        alu_slot_s = tail_q + PW'(mem_enq_s);
        if (mem_enq_s) begin
            addr_d[tail_q] = mem_addr;
            data_d[tail_q] = mem_data;
        end else begin
            addr_d[tail_q] = addr_d[tail_q];
        end
        if (alu_enq_s) begin
            addr_d[alu_slot_s] = alu_addr;
            data_d[alu_slot_s] = alu_data;
        end else begin
            addr_d[alu_slot_s] = addr_d[alu_slot_s];
        end
        tail_d  = tail_q + PW'(mem_enq_s) + PW'(alu_enq_s);
        count_d = count_q + CW'(mem_enq_s) + CW'(alu_enq_s) - CW'(pop_s);
    end

    // State registers; reset discards every queued write and clears the write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= {AW{1'b0}};
                data_q[i] <= {DW{1'b0}};
            end
            head_q     <= {PW{1'b0}};
            tail_q     <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= {AW{1'b0}};
            rf_wdata_q <= {DW{1'b0}};
        end else begin
            addr_q     <= addr_d;
            data_q     <= data_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // Pending bitmap and forwarding: scan oldest to youngest so the youngest match wins.
    always_comb begin
        pending_s    = {NR{1'b0}};
        hit1_s       = 1'b0;
        hit2_s       = 1'b0;
        data1_s      = {DW{1'b0}};
        data2_s      = {DW{1'b0}};
        scan_idx_s   = head_q;
        slot_valid_s = 1'b0;
        match1_s     = 1'b0;
        match2_s     = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx_s   = head_q + PW'(i);
            slot_valid_s = (CW'(i) < count_q);
            match1_s     = slot_valid_s & (addr_q[scan_idx_s] == fwd_addr1);
            match2_s     = slot_valid_s & (addr_q[scan_idx_s] == fwd_addr2);
            hit1_s       = hit1_s | match1_s;
            hit2_s       = hit2_s | match2_s;
            data1_s      = match1_s ? data_q[scan_idx_s] : data1_s;
            data2_s      = match2_s ? data_q[scan_idx_s] : data2_s;
            pending_s[addr_q[scan_idx_s]] = pending_s[addr_q[scan_idx_s]] | slot_valid_s;
        end
`ifdef WB_R0_ZERO_EN
        hit1_s       = (fwd_addr1 == {AW{1'b0}}) ? 1'b1 : hit1_s;
        data1_s      = (fwd_addr1 == {AW{1'b0}}) ? {DW{1'b0}} : data1_s;
        hit2_s       = (fwd_addr2 == {AW{1'b0}}) ? 1'b1 : hit2_s;
        data2_s      = (fwd_addr2 == {AW{1'b0}}) ? {DW{1'b0}} : data2_s;
        pending_s[0] = 1'b0;
`endif
    end

    assign alu_ready = alu_ready_s;
    assign mem_ready = mem_ready_s;
    assign rf_wen    = rf_wen_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign pending   = pending_s;
    assign fwd_hit1  = hit1_s;
    assign fwd_hit2  = hit2_s;
    assign fwd_data1 = data1_s;
    assign fwd_data2 = data2_s;
    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == {CW{1'b0}});

endmodule

// File: doc/rf_writeback_ctrl.md
Name: rf_writeback_ctrl

Overview:
- Write-side initiator for the 16-entry, 32-bit, single-write-port register file.
- Accepts results from two producers (single-cycle ALU and multi-cycle memory/load unit) over valid/ready handshakes.
- Buffers results in an in-order write queue and drains one entry per cycle onto the register file write port (wen/waddr/wdata).
- Publishes a pending-write bitmap and a two-port forwarding lookup so the decode stage can bypass values not yet written.

Parameters:
- DEPTH, 4, write-queue entries; power of two, minimum 2.
- AW, 4, register address width; 16 registers.
- DW, 32, data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-low.
- alu_valid  in  1  ALU result valid.
- alu_ready  out  1  ALU result accepted this cycle when high with alu_valid.
- alu_addr  in  AW  ALU destination register.
- alu_data  in  DW  ALU result.
- mem_valid  in  1  memory result valid.
- mem_ready  out  1  memory result accepted this cycle when high with mem_valid.
- mem_addr  in  AW  memory destination register.
- mem_data  in  DW  memory result.
- rf_wen  out  1  register file write enable.
- rf_waddr  out  AW  register file write address.
- rf_wdata  out  DW  register file write data.
- pending  out  2^AW  bit i set while any queued entry targets register i.
- fwd_addr1  in  AW  forwarding lookup address, port 1.
- fwd_addr2  in  AW  forwarding lookup address, port 2.
- fwd_hit1  out  1  queue holds a write to fwd_addr1.
- fwd_hit2  out  1  queue holds a write to fwd_addr2.
- fwd_data1  out  DW  youngest queued value for fwd_addr1; 0 when no hit.
- fwd_data2  out  DW  youngest queued value for fwd_addr2; 0 when no hit.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset (rst low, async): queue pointers and count cleared; rf_wen=0, rf_waddr=0, rf_wdata=0, pending=0, empty=1, full=0.
- Reset mid-operation discards all queued writes; none reach the register file.
- Storage: circular queue of DEPTH {addr, data} entries, head/tail pointers wrap modulo DEPTH, count 0..DEPTH.
- Drain:
  - rf_wen/rf_waddr/rf_wdata are registered outputs.
  - Each posedge with count>0 pops the head into the output registers with rf_wen=1; otherwise rf_wen=0 (addr/data hold).
  - The register file always accepts a write, so the pop is unconditional.
- Latency: a result accepted at edge N is popped at edge N+1 at the earliest (rf_wen high during cycle N+1) and written into the register file at edge N+2.
- Ready:
  - free = DEPTH - count. Pops in the same cycle are not credited; there is no pass-through.
  - mem_ready = (free >= 1).
  - alu_ready = (free >= 2) | (free == 1 & ~mem_valid).
  - Memory has priority; ready never depends on the producer's own valid.
- Simultaneous accept: mem entry enqueued first (older), ALU entry second; tail advances by 2.
- Push and pop in the same cycle: count += pushes - pop.
- Ordering: strictly in-order. Two entries to the same register are written in enqueue order; the later value wins.
- pending and fwd_* are combinational from queue contents only. The entry currently in the output register is excluded; the register file's own read covers it after the edge.
- Forwarding match scans valid entries; the youngest match (closest to tail) supplies data.
- full/empty are combinational from count.

Optional Feature:
- Macro WB_R0_ZERO_EN.
- Defined:
  - Results with addr==0 are accepted (ready rules unchanged) but not enqueued.
  - fwd_hitN=1 and fwd_dataN=0 whenever fwd_addrN==0.
  - pending[0] is forced 0.
- Undefined: register 0 is an ordinary register, handled like all others.

Test Plan:
- Reset: assert rst=0 mid-stream with 3 entries queued -> rf_wen=0 immediately, empty=1, pending=0; after release no write of those entries ever appears.
- Single ALU write: alu addr=5 data=0xDEADBEEF accepted at edge N -> pending[5]=1 and fwd_hit1=1, fwd_data1=0xDEADBEEF for fwd_addr1=5 before edge N+1; rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF during cycle N+1; pending[5]=0 after edge N+1.
- Simultaneous producers, count=2, DEPTH=4: mem(3,0x11) and alu(3,0x22) in same cycle -> both accepted; writes appear in order 0x11 then 0x22; fwd_data for addr 3 = 0x22 while both are queued.
- Full/backpressure: fill to count=4 -> full=1, alu_ready=0, mem_ready=0. At count=3 with mem_valid=1 -> mem_ready=1, alu_ready=0, mem entry taken.
- Wrap-around: stream 10 ALU writes (addr i, data 0x100+i) with producer stalls -> exactly 10 rf_wen pulses, in order, values correct across pointer wrap.
- WB_R0_ZERO_EN: alu addr=0 data=0x55 -> accepted, no rf_wen pulse, fwd_hit=1 and fwd_data=0 for fwd_addr=0; without macro -> rf_wen pulse with waddr=0, wdata=0x55.
